// File: rtl/display_pkg.sv
// Shared definitions for the display timing / test-pattern generator:
// control-register bit positions, pattern encodings and the colour-bar table.
package display_pkg;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_HPOL_BIT  = 1;
    localparam int CTRL_VPOL_BIT  = 2;
    localparam int CTRL_PAT_LSB   = 8;
    localparam int CTRL_PAT_W     = 3;
    localparam int CTRL_SHIFT_LSB = 16;
    localparam int CTRL_SHIFT_W   = 4;

    typedef enum logic [2:0] {
        PAT_SOLID   = 3'd0,
        PAT_BARS    = 3'd1,
        PAT_CHECKER = 3'd2,
        PAT_HRAMP   = 3'd3,
        PAT_VRAMP   = 3'd4
    } pat_mode_e;

    // {R,G,B} full-scale flags, index 0 = white ... index 7 = black
    localparam logic [7:0][2:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                           3'b010, 3'b011, 3'b110, 3'b111};

endpackage

// File: rtl/display_pattern_engine.sv
// Combinational test-pattern engine: maps the active-region pixel coordinate
// and the shadowed pattern settings to the next {pad, R, G, B} pixel word.
module display_pattern_engine
    import display_pkg::*;
#(
    parameter int C_CNT_WIDTH   = 12,
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_RED_WIDTH   = 8,
    parameter int C_GREEN_WIDTH = 8,
    parameter int C_BLUE_WIDTH  = 8
) (
    input  logic [C_CNT_WIDTH-1:0]                             x_i,
    input  logic [C_CNT_WIDTH-1:0]                             y_i,
    input  logic                                               active_i,
    input  logic [CTRL_PAT_W-1:0]                              mode_i,
    input  logic [CTRL_SHIFT_W-1:0]                            shift_i,
    input  logic [C_RED_WIDTH+C_GREEN_WIDTH+C_BLUE_WIDTH-1:0]  test_data_i,
    output logic [C_DATA_WIDTH-1:0]                            pix_data_o
);

    localparam int RGB_W = C_RED_WIDTH + C_GREEN_WIDTH + C_BLUE_WIDTH;

    logic [C_CNT_WIDTH-1:0] xs_s;
    logic [C_CNT_WIDTH-1:0] ys_s;
    logic [2:0]             bar_s;
    logic [RGB_W-1:0]       rgb_s;
    logic                   unused_s;

    assign xs_s     = x_i >> shift_i;
    assign ys_s     = y_i >> shift_i;
    assign bar_s    = BAR_RGB[xs_s[2:0]];
    assign unused_s = ^{xs_s, ys_s};

    // Pattern select; ramps use size casts so each channel truncates or zero-extends
    always_comb begin
        rgb_s = '0;
        if (!active_i) begin
            rgb_s = '0;
        end else begin
            case (mode_i)
                PAT_SOLID:   rgb_s = test_data_i;
                PAT_BARS:    rgb_s = {{C_RED_WIDTH{bar_s[2]}}, {C_GREEN_WIDTH{bar_s[1]}},
                                      {C_BLUE_WIDTH{bar_s[0]}}};
                PAT_CHECKER: rgb_s = (xs_s[0] ^ ys_s[0]) ? test_data_i : '0;
                PAT_HRAMP:   rgb_s = {C_RED_WIDTH'(xs_s), C_GREEN_WIDTH'(xs_s), C_BLUE_WIDTH'(xs_s)};
                PAT_VRAMP:   rgb_s = {C_RED_WIDTH'(ys_s), C_GREEN_WIDTH'(ys_s), C_BLUE_WIDTH'(ys_s)};
                default:     rgb_s = '0;
            endcase
        end
    end

    assign pix_data_o = C_DATA_WIDTH'(rgb_s);

endmodule

// File: rtl/display_timing_pattern_gen.sv
// Video timing and test-pattern generator: h/v counters, frame-boundary shadowed
// configuration and registered XSVI-style outputs in the pix_clk domain.
module display_timing_pattern_gen
    import display_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_CNT_WIDTH        = 12,
    parameter int C_DATA_WIDTH       = 32,
    parameter int C_RED_WIDTH        = 8,
    parameter int C_GREEN_WIDTH      = 8,
    parameter int C_BLUE_WIDTH       = 8
) (
    input  logic                          pix_clk,
    input  logic                          areset,
    input  logic                          pix_clk_locked,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] ctrl,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] test_data,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] hs_end,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] hbp_end,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] hfp_begin,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] hline_end,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] vs_end,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] vbp_end,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] vfp_begin,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] vline_end,
    output logic [C_DATA_WIDTH-1:0]       pix_data,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          vde,
    output logic                          frame_start
);

    localparam int CW    = C_CNT_WIDTH;
    localparam int RGB_W = C_RED_WIDTH + C_GREEN_WIDTH + C_BLUE_WIDTH;

    typedef struct packed {
        logic                    pol_h;
        logic                    pol_v;
        logic [CTRL_PAT_W-1:0]   mode;
        logic [CTRL_SHIFT_W-1:0] shift;
        logic [RGB_W-1:0]        test;
        logic [CW-1:0]           hs_end;
        logic [CW-1:0]           hbp_end;
        logic [CW-1:0]           hfp_begin;
        logic [CW-1:0]           hline_end;
        logic [CW-1:0]           vs_end;
        logic [CW-1:0]           vbp_end;
        logic [CW-1:0]           vfp_begin;
        logic [CW-1:0]           vline_end;
    } cfg_t;

    cfg_t                    cfg_in_s, cfg_s, cfg_d, cfg_q;
    logic                    rst_s, en_s, en_q, rise_s, load_s;
    logic                    h_last_s, v_last_s, active_s, unused_s;
    logic [CW-1:0]           hcount_d, hcount_q, vcount_d, vcount_q, x_s, y_s;
    logic [C_DATA_WIDTH-1:0] pix_s, pix_data_d, pix_data_q;
    logic                    hsync_d, hsync_q, vsync_d, vsync_q;
    logic                    vde_d, vde_q, frame_start_d, frame_start_q;

    // Loss of MMCM lock behaves exactly like areset
    assign rst_s    = areset | ~pix_clk_locked;
    assign en_s     = ctrl[CTRL_EN_BIT];
    assign unused_s = ^{ctrl, test_data, hs_end, hbp_end, hfp_begin, hline_end,
                        vs_end, vbp_end, vfp_begin, vline_end};

    // Register-file view truncated to the shadowed fields
    always_comb begin
        cfg_in_s           = '0;
        cfg_in_s.pol_h     = ctrl[CTRL_HPOL_BIT];
        cfg_in_s.pol_v     = ctrl[CTRL_VPOL_BIT];
        cfg_in_s.mode      = ctrl[CTRL_PAT_LSB +: CTRL_PAT_W];
        cfg_in_s.shift     = ctrl[CTRL_SHIFT_LSB +: CTRL_SHIFT_W];
        cfg_in_s.test      = test_data[RGB_W-1:0];
        cfg_in_s.hs_end    = hs_end[CW-1:0];
        cfg_in_s.hbp_end   = hbp_end[CW-1:0];
        cfg_in_s.hfp_begin = hfp_begin[CW-1:0];
        cfg_in_s.hline_end = hline_end[CW-1:0];
        cfg_in_s.vs_end    = vs_end[CW-1:0];
        cfg_in_s.vbp_end   = vbp_end[CW-1:0];
        cfg_in_s.vfp_begin = vfp_begin[CW-1:0];
        cfg_in_s.vline_end = vline_end[CW-1:0];
    end

    // On the enable edge the shadow is loaded in the same cycle as pixel (0,0) is
    // computed, so that pixel bypasses the shadow and uses the incoming settings.
    assign rise_s   = en_s & ~en_q;
    assign cfg_s    = rise_s ? cfg_in_s : cfg_q;
    assign h_last_s = (cfg_s.hline_end <= CW'(1)) || (hcount_q == cfg_s.hline_end - CW'(1));
    assign v_last_s = (cfg_s.vline_end <= CW'(1)) || (vcount_q == cfg_s.vline_end - CW'(1));
    assign load_s   = rise_s | (en_s & h_last_s & v_last_s);
    assign cfg_d    = load_s ? cfg_in_s : cfg_q;

    assign active_s = (hcount_q >= cfg_s.hbp_end) && (hcount_q < cfg_s.hfp_begin) &&
                      (vcount_q >= cfg_s.vbp_end) && (vcount_q < cfg_s.vfp_begin);
    assign x_s      = hcount_q - cfg_s.hbp_end;
    assign y_s      = vcount_q - cfg_s.vbp_end;

    display_pattern_engine #(
        .C_CNT_WIDTH   (C_CNT_WIDTH),
        .C_DATA_WIDTH  (C_DATA_WIDTH),
        .C_RED_WIDTH   (C_RED_WIDTH),
        .C_GREEN_WIDTH (C_GREEN_WIDTH),
        .C_BLUE_WIDTH  (C_BLUE_WIDTH)
    ) u_engine (
        .x_i         (x_s),
        .y_i         (y_s),
        .active_i    (active_s),
        .mode_i      (cfg_s.mode),
        .shift_i     (cfg_s.shift),
        .test_data_i (cfg_s.test),
        .pix_data_o  (pix_s)
    );

    // Counter next state; degenerate line/frame lengths pin the counter at 0
    always_comb begin
        hcount_d = '0;
        vcount_d = '0;
        if (en_s) begin
            if (h_last_s) begin
                hcount_d = '0;
                vcount_d = v_last_s ? '0 : vcount_q + CW'(1);
            end else begin
                hcount_d = hcount_q + CW'(1);
                vcount_d = vcount_q;
            end
        end else begin
            hcount_d = '0;
            vcount_d = '0;
        end
    end

    // Output next state; while disabled the syncs idle at their inactive level
    always_comb begin
        hsync_d       = 1'b0;
        vsync_d       = 1'b0;
        vde_d         = 1'b0;
        pix_data_d    = '0;
        frame_start_d = 1'b0;
        if (en_s) begin
            hsync_d       = (hcount_q < cfg_s.hs_end) ^ cfg_s.pol_h;
            vsync_d       = (vcount_q < cfg_s.vs_end) ^ cfg_s.pol_v;
            vde_d         = active_s;
            pix_data_d    = pix_s;
            frame_start_d = (hcount_q == '0) && (vcount_q == '0);
        end else begin
            hsync_d = cfg_s.pol_h;
            vsync_d = cfg_s.pol_v;
        end
    end

    // State, shadow and output registers
    always_ff @(posedge pix_clk or posedge rst_s) begin
        if (rst_s) begin
            en_q          <= 1'b0;
            cfg_q         <= '0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            vde_q         <= 1'b0;
            pix_data_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            en_q          <= en_s;
            cfg_q         <= cfg_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            vde_q         <= vde_d;
            pix_data_q    <= pix_data_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_data    = pix_data_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vde         = vde_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/display_timing_pattern_gen.md
# display_timing_pattern_gen

Parametrised second-generation video timing and test-pattern generator for the display pipeline. It produces XSVI-style hsync/vsync/vde/pix_data from AXI-programmed timing registers. Over the first-generation block it adds generic counter width, selectable sync polarity, and frame-boundary shadowing of all configuration. It also provides five hardware patterns and a frame-start pulse. It sits between the AXI-Lite register file and the RGB-to-DVI/HDMI encoder, in the pix_clk domain.

## Interface
- C_S_AXI_DATA_WIDTH, 32, width of every register input
- C_CNT_WIDTH, 12, width of h/v counters; register values truncated to this width
- C_DATA_WIDTH, 32, pix_data width; must be ≥ C_RED_WIDTH+C_GREEN_WIDTH+C_BLUE_WIDTH
- C_RED_WIDTH / C_GREEN_WIDTH / C_BLUE_WIDTH, 8 / 8 / 8, channel widths
- pix_clk  in  1  pixel clock; the single clock of the block
- areset  in  1  asynchronous, active-high reset
- pix_clk_locked  in  1  MMCM lock; low acts exactly like areset (combined internally, asynchronous assert)
- ctrl  in  C_S_AXI_DATA_WIDTH  [0] enable, [1] hsync active-low, [2] vsync active-low, [10:8] pattern, [19:16] pattern shift S
- test_data  in  C_S_AXI_DATA_WIDTH  solid/checker colour {R,G,B} packed from bit 0 (B lowest)
- hs_end, hbp_end, hfp_begin, hline_end  in  C_S_AXI_DATA_WIDTH  horizontal timing in pixels
- vs_end, vbp_end, vfp_begin, vline_end  in  C_S_AXI_DATA_WIDTH  vertical timing in lines
- pix_data  out  C_DATA_WIDTH  pixel, {pad 0, R, G, B}
- hsync, vsync, vde  out  1  sync and data enable
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0)

## Operation
- Shadow set: ctrl[19:1], test_data and all 8 timing registers. Loaded on the enable rising edge (0→1, seen registered) and on the last pixel of every frame (hcount==hline_end-1 && vcount==vline_end-1). Between loads, input changes have no effect.
- ctrl[0] is used live. When it is low, counters are held at 0 and outputs are forced as follows on the next edge:
  - hsync = shadow hsync polarity bit; vsync = shadow vsync polarity bit
  - vde = 0, pix_data = 0, frame_start = 0
- Counters: hcount increments each cycle and wraps to 0 at hline_end-1. vcount increments on each h-wrap and wraps to 0 at vline_end-1. All arithmetic is C_CNT_WIDTH, modulo 2^C_CNT_WIDTH.
- Raw sync (pre-polarity): hs = hcount<hs_end; vs = vcount<vs_end. Output level = raw XOR polarity bit.
- Active region: hbp_end ≤ hcount < hfp_begin and vbp_end ≤ vcount < vfp_begin. Within it, x = hcount-hbp_end and y = vcount-vbp_end.
- Patterns (shadow ctrl[10:8]); outside the active region pix_data = 0:
  - 0: solid test_data.
  - 1: colour bars. Index = (x>>S)[2:0]; order is white, yellow, cyan, green, magenta, red, blue, black. Each channel is full-scale or 0.
  - 2: checker. ((x>>S)^(y>>S))[0] selects test_data when 1, else 0.
  - 3: horizontal ramp. Every channel = low bits of (x>>S), truncated or zero-extended to the channel width.
  - 4: vertical ramp, as mode 3 using y.
  - 5–7: reserved; output 0.

## Timing
- Reset or !locked: counters 0, shadows 0. Outputs: hsync=0, vsync=0, vde=0, pix_data=0, frame_start=0.
- All outputs are registered with one cycle of latency from counter state, mutually aligned. vde and pix_data are never skewed.
- The first enabled cycle after enable rises shows outputs for (0,0), with frame_start=1.
- frame_start is high exactly one cycle per frame. It never fires while disabled.
- A shadow load on the last pixel takes effect for pixel (0,0) of the next frame. That frame's first-pixel outputs already use the new polarity and pattern.
- Reset mid-frame: immediate asynchronous return to reset values. The frame restarts at (0,0) after reset release and enable.
- Degenerate settings are legal and must not hang:
  - hline_end ≤ 1 or vline_end ≤ 1: the counter stays at 0.
  - hfp_begin ≤ hbp_end: vde is never asserted.

## Structure
- Shared package display_pkg holds:
  - ctrl bit positions
  - pattern mode encodings (PAT_SOLID..PAT_VRAMP)
  - the 8-entry colour-bar constant table
- One sub-module, display_pattern_engine. It is combinational and takes x, y, active, mode, S and test_data, returning the next pix_data. The top level holds the counters, shadows and output registers.

## Test plan
- 640x480 timing (hs_end=96, hbp_end=144, hfp_begin=784, hline_end=800, vs_end=2, vbp_end=35, vfp_begin=515, vline_end=525), mode 0, test_data=0x00FF8000 → 307200 vde cycles per frame; every active pix_data = 0x00FF8000; hsync high 96 cycles per line; frame_start period 420000.
- Same timing, ctrl[2:1]=2'b11 → hsync low 96 and vsync low 2 lines per period; idle level high; disabling drives both high.
- Mode 1, S=6 → pixels x=0..63 = 0x00FFFFFF; x=64 = 0x00FFFF00; x=448..511 = 0x00000000; x=512 wraps back to white.
- Change hline_end and the pattern mid-frame → the current frame is unchanged; the new values apply exactly from the next frame_start pixel.
- Assert areset during the active region (and, separately, drop pix_clk_locked) → all outputs 0 asynchronously; after release, frame_start occurs 1 cycle after the first enabled edge.
- Mode 2, S=3, test_data=0x00123456 → (0,0)=0, (8,0)=0x00123456, (8,8)=0; modes 5–7 → pix_data=0 with vde still toggling.
